// File: rtl/fx2_gpio_bridge_if.sv
// FX2 slave-FIFO strobe, flag and port-A pins used by fx2_gpio_bridge.
// FX2_FD stays a plain inout on the bridge because it is a shared pad.
interface fx2_gpio_bridge_if;
  logic [2:0] FX2_flags;
  logic       FX2_PA_7;
  logic       FX2_SLRD;
  logic       FX2_SLWR;
  logic       FX2_PA_2;
  logic       FX2_PA_3;
  logic       FX2_PA_4;
  logic       FX2_PA_5;
  logic       FX2_PA_6;

  modport master (
    input  FX2_flags, FX2_PA_7,
    output FX2_SLRD, FX2_SLWR, FX2_PA_2, FX2_PA_3, FX2_PA_4, FX2_PA_5, FX2_PA_6
  );

  modport slave (
    output FX2_flags, FX2_PA_7,
    input  FX2_SLRD, FX2_SLWR, FX2_PA_2, FX2_PA_3, FX2_PA_4, FX2_PA_5, FX2_PA_6
  );
endinterface

// File: rtl/fx2_gpio_bridge.sv
// Command-driven GPIO bridge on the FX2 slave FIFOs: FIFO2 commands in, FIFO4 responses out.
// Define FX2_GPIO_EDGE_EN to add the sticky change register and the READ_CHG (0x03) command.
module fx2_gpio_bridge #(
  parameter int unsigned            GPIO_IN_W      = 16,
  parameter int unsigned            GPIO_OUT_W     = 8,
  parameter logic [GPIO_OUT_W-1:0]  GPIO_OUT_RESET = '0,
  parameter int unsigned            SYNC_STAGES    = 2
) (
  input  logic                  FX2_CLK,
  input  logic                  FX2_RSTn,
  inout  wire  [7:0]            FX2_FD,
  fx2_gpio_bridge_if.master     fx2,
  input  logic [GPIO_IN_W-1:0]  gpio_in,
  output logic [GPIO_OUT_W-1:0] gpio_out
);

  localparam int unsigned NBI   = (GPIO_IN_W + 7) / 8;
  localparam int unsigned NBO   = (GPIO_OUT_W + 7) / 8;
  localparam int unsigned NBMAX = (NBI > NBO) ? NBI : NBO;
  localparam int unsigned TXW   = 8 * NBMAX;
  localparam int unsigned SW    = 8 * NBO;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_WDATA = 3'd2;
  localparam logic [2:0] S_TURN  = 3'd3;
  localparam logic [2:0] S_SEND  = 3'd4;
  localparam logic [2:0] S_PKT   = 3'd5;
  localparam logic [2:0] S_BACK  = 3'd6;

  localparam logic [7:0] CMD_READ_IN   = 8'h00;
  localparam logic [7:0] CMD_WRITE_OUT = 8'h01;
  localparam logic [7:0] CMD_READ_OUT  = 8'h02;

  logic [2:0]           state;
  logic [2:0]           idx;
  logic [2:0]           nb;
  logic [TXW-1:0]       tx_q;
  logic [SW-1:0]        stage_q;
  logic [SW-1:0]        stage_next;
  logic [GPIO_IN_W-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_IN_W-1:0] synced;
  logic                 rd_state;
  logic                 consume;
  logic                 fd_oe;
  logic [7:0]           fd_byte;
  logic                 unused_pins;

  assign unused_pins = ^{fx2.FX2_flags[1], fx2.FX2_PA_7};

  always_ff @(posedge FX2_CLK) begin
    if (!FX2_RSTn) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // A FIFO2 byte is consumed exactly when SLRD is low and the FIFO reports data.
  assign rd_state = (state == S_CMD) || (state == S_WDATA);
  assign consume  = rd_state && fx2.FX2_flags[0];
  assign fd_oe    = (state == S_SEND) || (state == S_PKT);

  assign fx2.FX2_SLRD = !consume;
  assign fx2.FX2_SLWR = !((state == S_SEND) && fx2.FX2_flags[2]);
  assign fx2.FX2_PA_6 = (state != S_PKT);
  assign fx2.FX2_PA_2 = !((state == S_IDLE) || rd_state || (state == S_BACK));
  assign fx2.FX2_PA_3 = 1'b1;
  assign fx2.FX2_PA_5 = (state == S_TURN) || fd_oe;
  assign fx2.FX2_PA_4 = 1'b0;

  always_comb begin
    fd_byte = tx_q[7:0];
    for (int unsigned b = 0; b < NBMAX; b++)
      if (idx == 3'(b)) fd_byte = tx_q[8*b +: 8];
  end

  assign FX2_FD = fd_oe ? fd_byte : 'z;

  always_comb begin
    stage_next = stage_q;
    for (int unsigned b = 0; b < NBO; b++)
      if (idx == 3'(b)) stage_next[8*b +: 8] = FX2_FD;
  end

`ifdef FX2_GPIO_EDGE_EN
  localparam logic [7:0] CMD_READ_CHG = 8'h03;

  logic [GPIO_IN_W-1:0] chg_q;
  logic                 capture;

  // Clearing on capture still keeps a change seen on the same edge.
  assign capture = consume && (state == S_CMD) && (FX2_FD == CMD_READ_CHG);

  always_ff @(posedge FX2_CLK) begin
    if (!FX2_RSTn) chg_q <= '0;
    else           chg_q <= (capture ? '0 : chg_q) |
                            (sync_q[SYNC_STAGES-1] ^ sync_q[SYNC_STAGES-2]);
  end
`endif

  always_ff @(posedge FX2_CLK) begin
    if (!FX2_RSTn) begin
      state    <= S_IDLE;
      idx      <= '0;
      nb       <= '0;
      tx_q     <= '0;
      stage_q  <= '0;
      gpio_out <= GPIO_OUT_RESET;
    end else begin
      case (state)
        S_IDLE: state <= S_CMD;
        S_CMD: begin
          if (consume) begin
            case (FX2_FD)
              CMD_READ_IN: begin
                tx_q  <= TXW'(synced);
                nb    <= 3'(NBI);
                state <= S_TURN;
              end
              CMD_WRITE_OUT: begin
                idx   <= '0;
                state <= S_WDATA;
              end
              CMD_READ_OUT: begin
                tx_q  <= TXW'(gpio_out);
                nb    <= 3'(NBO);
                state <= S_TURN;
              end
`ifdef FX2_GPIO_EDGE_EN
              CMD_READ_CHG: begin
                tx_q  <= TXW'(chg_q);
                nb    <= 3'(NBI);
                state <= S_TURN;
              end
`endif
              default: state <= S_CMD;
            endcase
          end
        end
        S_WDATA: begin
          if (consume) begin
            stage_q <= stage_next;
            if (idx == 3'(NBO - 1)) begin
              gpio_out <= stage_next[GPIO_OUT_W-1:0];
              idx      <= '0;
              state    <= S_CMD;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        S_TURN: begin
          idx   <= '0;
          state <= S_SEND;
        end
        S_SEND: begin
          if (fx2.FX2_flags[2]) begin
            if (idx == nb - 3'd1) state <= S_PKT;
            else                  idx   <= idx + 3'd1;
          end
        end
        S_PKT:   state <= S_BACK;
        S_BACK:  state <= S_CMD;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fx2_gpio_bridge.sv
// Scoreboard bench for fx2_gpio_bridge: host FIFO2/FIFO4 model, byte-stream reference, FIFO4 monitor.
module tb_fx2_gpio_bridge;
  localparam int unsigned   IW      = 16;
  localparam int unsigned   OW      = 8;
  localparam int unsigned   SS      = 2;
  localparam int unsigned   NBI     = (IW + 7) / 8;
  localparam int unsigned   NBO     = (OW + 7) / 8;
  localparam logic [OW-1:0] OUT_RST = 8'hA5;

  typedef struct {
    logic [7:0] b;
    int         gap;
  } host_byte_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [IW-1:0] gpio_in = '0;
  logic [OW-1:0] gpio_out;
  wire  [7:0]    fd;
  logic [7:0]    host_byte = '0;

  fx2_gpio_bridge_if bus();

  // The FX2 drives the data bus whenever SLOE is asserted.
  assign fd = (bus.FX2_PA_2 == 1'b0) ? host_byte : 8'bz;

  fx2_gpio_bridge #(
    .GPIO_IN_W      (IW),
    .GPIO_OUT_W     (OW),
    .GPIO_OUT_RESET (OUT_RST),
    .SYNC_STAGES    (SS)
  ) dut (
    .FX2_CLK  (clk),
    .FX2_RSTn (rstn),
    .FX2_FD   (fd),
    .fx2      (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  host_byte_t    h2q[$];
  logic [8:0]    expq[$];
  logic [IW-1:0] hist[$];
  logic [OW-1:0] out_model = OUT_RST;
  logic [IW-1:0] chg_model = '0;
  logic [31:0]   wval = '0;
  int            wleft = 0;
  int            full_cnt = 0;
  bit            rand_full_en = 1'b0;
  bit            stall_second = 1'b0;
  bit            toggle_on_read = 1'b0;
  int            pkt_writes = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    host_byte_t e;
    e.b   = b;
    e.gap = gap;
    h2q.push_back(e);
  endtask

  task automatic expect_pkt(input logic [31:0] v, input int unsigned nbytes);
    for (int unsigned i = 0; i < nbytes; i++) expq.push_back({1'b0, v[8*i +: 8]});
    expq.push_back(9'h100);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((h2q.size() != 0 || expq.size() != 0 || wleft != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d host bytes, %0d responses pending, required 0 after %0d cycles",
               h2q.size(), expq.size(), budget);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Host side: FIFO2 source, FIFO4 sink flow control, and the reference model of the command stream.
  initial begin : host
    logic          take;
    logic          wr;
    logic          avail;
    logic          rand_full;
    logic [7:0]    b;
    logic [IW-1:0] d;
    bit            do_toggle;
    bit            do_stall;
    bus.FX2_flags = 3'b100;
    bus.FX2_PA_7  = 1'b1;
    for (int i = 0; i <= int'(SS); i++) hist.push_back('0);
    forever begin
      @(negedge clk);
      chk("gpio_out", 32'(gpio_out), 32'(out_model));
      hist.push_front(rstn ? gpio_in : '0);
      void'(hist.pop_back());
      d = hist[SS] ^ hist[SS-1];
      take = rstn && !bus.FX2_SLRD && bus.FX2_flags[0];
      wr   = !bus.FX2_SLWR && bus.FX2_flags[2];
      do_toggle = 1'b0;
      do_stall  = 1'b0;
      if (wr) begin
        pkt_writes++;
        if (stall_second && pkt_writes == 1) do_stall = 1'b1;
      end
      if (!bus.FX2_PA_6) pkt_writes = 0;
      if (!rstn) begin
        out_model = OUT_RST;
        chg_model = '0;
        wleft     = 0;
      end else begin
        if (take) begin
          b = h2q[0].b;
          if (wleft > 0) begin
            wval[8*(int'(NBO) - wleft) +: 8] = b;
            wleft--;
            if (wleft == 0) out_model = wval[OW-1:0];
          end else begin
            case (b)
              8'h00: begin
                expect_pkt(32'(hist[SS]), NBI);
                do_toggle = toggle_on_read;
              end
              8'h01: begin
                wleft = int'(NBO);
                wval  = '0;
              end
              8'h02: expect_pkt(32'(out_model), NBO);
`ifdef FX2_GPIO_EDGE_EN
              8'h03: begin
                expect_pkt(32'(chg_model), NBI);
                chg_model = '0;
              end
`endif
              default: ;
            endcase
          end
        end
        chg_model = chg_model | d;
      end
      @(posedge clk);
      #1;
      if (take) void'(h2q.pop_front());
      if (do_toggle) gpio_in = '1;
      if (do_stall) full_cnt = 5;
      else if (full_cnt > 0) full_cnt--;
      rand_full = rand_full_en && ($urandom_range(0, 3) == 0);
      if (h2q.size() > 0 && h2q[0].gap > 0) begin
        h2q[0].gap = h2q[0].gap - 1;
        avail = 1'b0;
      end else begin
        avail = (h2q.size() > 0);
      end
      bus.FX2_flags[0] = avail;
      bus.FX2_flags[2] = (full_cnt == 0) && !rand_full;
      host_byte = (h2q.size() > 0) ? h2q[0].b : 8'h00;
    end
  end

  // FIFO4 monitor: every accepted write and PKTEND is matched against the expected response queue.
  initial begin : mon
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (!bus.FX2_flags[2]) begin
          vectors++;
          if (!bus.FX2_SLWR) begin
            miscompares++;
            $display("FAIL slwr_while_full: SLWR=0 required 1 at %0t", $time);
          end
        end
        if (!bus.FX2_SLWR && bus.FX2_flags[2]) begin
          vectors++;
          if (expq.size() == 0) begin
            miscompares++;
            $display("FAIL fifo4_write: unexpected byte %h, none expected at %0t", fd, $time);
          end else begin
            e = expq.pop_front();
            if (e !== {1'b0, fd} || {bus.FX2_PA_5, bus.FX2_PA_4} !== 2'b10) begin
              miscompares++;
              $display("FAIL fifo4_write: got %h adr %b expected %h adr 10 at %0t",
                       {1'b0, fd}, {bus.FX2_PA_5, bus.FX2_PA_4}, e, $time);
            end
          end
        end
        if (!bus.FX2_PA_6) begin
          vectors++;
          if (expq.size() == 0) begin
            miscompares++;
            $display("FAIL pktend: unexpected PKTEND, none expected at %0t", $time);
          end else begin
            e = expq.pop_front();
            if (e !== 9'h100) begin
              miscompares++;
              $display("FAIL pktend: got PKTEND expected %h at %0t", e, $time);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d responses pending", expq.size());
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0] r;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_slrd",   32'(bus.FX2_SLRD), 32'd1);
    chk("rst_slwr",   32'(bus.FX2_SLWR), 32'd1);
    chk("rst_pktend", 32'(bus.FX2_PA_6), 32'd1);
    chk("rst_sloe",   32'(bus.FX2_PA_2), 32'd0);
    chk("rst_pa3",    32'(bus.FX2_PA_3), 32'd1);
    chk("rst_adr",    32'({bus.FX2_PA_5, bus.FX2_PA_4}), 32'd0);
    chk("rst_gpio",   32'(gpio_out), 32'hA5);
    @(posedge clk);
    #1;
    rstn    = 1'b1;
    gpio_in = 16'h1234;
    repeat (6) begin @(posedge clk); #1; end

    toggle_on_read = 1'b1;
    send(8'h00, 0);
    wait_idle(200);
    toggle_on_read = 1'b0;

    send(8'h01, 0);
    send(8'h5A, 10);
    wait_idle(200);
    chk("write_out", 32'(gpio_out), 32'h5A);
    send(8'h02, 0);
    wait_idle(200);

    gpio_in = 16'h1234;
    repeat (5) begin @(posedge clk); #1; end
    stall_second = 1'b1;
    send(8'h00, 2);
    wait_idle(200);
    stall_second = 1'b0;

    send(8'h03, 0);
    wait_idle(200);
    gpio_in = 16'h123C;
    @(posedge clk);
    #1;
    gpio_in = 16'h1234;
    repeat (5) begin @(posedge clk); #1; end
    send(8'h03, 0);
    send(8'h03, 0);
    send(8'h02, 0);
    wait_idle(200);

    rand_full_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: send(8'h00, $urandom_range(0, 2));
        3, 4: begin
          send(8'h01, $urandom_range(0, 2));
          for (int unsigned k = 0; k < NBO; k++) send(8'($urandom), $urandom_range(0, 4));
        end
        5, 6: send(8'h02, $urandom_range(0, 2));
        7:    send(8'h03, $urandom_range(0, 2));
        default: begin
          r = 8'($urandom_range(4, 255));
          send(r, $urandom_range(0, 2));
        end
      endcase
      if ($urandom_range(0, 2) == 0) gpio_in = IW'($urandom);
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    wait_idle(6000);
    rand_full_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fx2_gpio_bridge.md
# fx2_gpio_bridge

Command-driven GPIO bridge on the FX2 slave-FIFO interface, the successor to the single-purpose GPIO readback block. The host writes command packets into FIFO2. The block decodes each command byte and does one of two things: returns a coherent, parametrised-width snapshot of the synchronised inputs on FIFO4, or updates a parametrised-width output register. The block sits directly on the FX2 pins and is clocked by the FX2 interface clock.

## Interface
- GPIO_IN_W, 16: input bus width, 1..32; NBI = (GPIO_IN_W+7)/8 response bytes.
- GPIO_OUT_W, 8: output bus width, 1..32; NBO = (GPIO_OUT_W+7)/8 payload bytes.
- GPIO_OUT_RESET, 0: reset value of gpio_out.
- SYNC_STAGES, 2: synchroniser depth on gpio_in, minimum 2.
- FX2_CLK  in  1  FX2 interface clock; the only clock.
- FX2_RSTn  in  1  synchronous, active-low reset.
- FX2_FD  inout  8  FIFO data bus.
- FX2_flags  in  3  [0] FIFO2 not-empty, [1] FIFO3 not-empty (unused), [2] FIFO4 not-full; all active-low-empty/full.
- FX2_PA_7  in  1  FIFO5 not-full (unused).
- FX2_SLRD, FX2_SLWR  out  1  read/write strobes, active-low.
- FX2_PA_2  out  1  SLOE, active-low.
- FX2_PA_3  out  1  tied 1.
- FX2_PA_5:FX2_PA_4  out  2  FIFOADR.
- FX2_PA_6  out  1  PKTEND, active-low.
- gpio_in  in  GPIO_IN_W  asynchronous inputs.
- gpio_out  out  GPIO_OUT_W  registered outputs.

## Operation
- Commands are byte-serial in FIFO2. Packet boundaries are ignored, and a command may span packets.
  - 0x00 READ_IN: snapshot the synchronised gpio_in, send NBI bytes LSB-first on FIFO4, then PKTEND.
  - 0x01 WRITE_OUT: consume the next NBO bytes LSB-first, then update gpio_out. No response.
  - 0x02 READ_OUT: send the current gpio_out as NBO bytes, then PKTEND.
  - Any other byte: discarded, and the FSM stays in CMD.
- States:
  - IDLE: FIFOADR=00, SLOE active. Go to CMD.
  - CMD: SLRD = FIFO2 available. On a consumed byte, decode it: 0x01 goes to WDATA; 0x00 and 0x02 go to TURN.
  - WDATA: SLRD = available. Shift bytes into the staging register. On the NBO-th byte, commit staging to gpio_out and go to CMD.
  - TURN: SLOE off, FIFOADR=10. Lasts one cycle, then SEND.
  - SEND: FD driven. SLWR = FIFO4 ready. The byte index advances only on an accepted write. After byte NB-1 is accepted, go to PKT.
  - PKT: PKTEND asserted for one cycle, then BACK.
  - BACK: FIFOADR=00, SLOE asserted, FD released. Lasts one cycle, then CMD.
- A byte counts as consumed on a clock edge only when SLRD is asserted and FIFO2 is available. Data is latched at that same edge.
- The snapshot is taken at the edge that consumes the READ_IN byte. All NBI bytes come from that one snapshot. Unused upper bits of the last byte are 0.
- gpio_out changes only on commit; a partial WRITE_OUT never alters it. WDATA waits indefinitely on an empty FIFO2.
- FD is driven only in SEND and PKT.

## Timing
- Reset (FX2_RSTn=0 at an edge), values take effect at the next edge:
  - state IDLE
  - FX2_SLRD=1, FX2_SLWR=1, FX2_PA_6=1
  - FX2_PA_2=0, FIFOADR=00, FD hi-Z
  - gpio_out=GPIO_OUT_RESET, staging and counters 0
  - synchronisers 0
- Reset mid-SEND aborts the packet with no PKTEND. Reset mid-WDATA discards staging.
- gpio_in to snapshot-visible latency: SYNC_STAGES cycles.
- READ_IN with FIFO4 always ready:
  - command consumed at edge N
  - TURN N+1
  - writes at edges N+2..N+1+NBI
  - PKTEND at N+2+NBI
  - BACK, then CMD at N+4+NBI
- FIFO4 full during SEND: SLWR is deasserted and FD holds the current byte.
- WRITE_OUT: gpio_out changes at the edge that consumes the last payload byte; visible on the following cycle.
- FX2_PA_3 is constant 1.

## Configuration
- FX2_GPIO_EDGE_EN defined:
  - Adds a GPIO_IN_W sticky change register, which sets on any bit change between the last two synchroniser stages.
  - Adds command 0x03 READ_CHG: sends NBI bytes of the change register captured at the command edge, then PKTEND.
  - The capture clears the register. A change occurring on that same edge stays set.
  - Reset clears the register.
- Undefined: no change register; 0x03 is an unknown byte and is discarded.

## Test plan
- Reset with GPIO_OUT_RESET=0xA5 -> gpio_out=0xA5, SLRD/SLWR/PKTEND high, PA_2 low, FD hi-Z.
- gpio_in=0x1234 stable, host sends 0x00 -> FIFO4 receives 0x34, 0x12, then one PKTEND; return to CMD.
- gpio_in toggles to 0xFFFF on the cycle after the 0x00 byte is consumed -> response still 0x34, 0x12.
- Host sends 0x01 in one packet and 0x5A in the next (FIFO2 empty 10 cycles between) -> gpio_out unchanged until 0x5A is consumed, then 0x5A. A following 0x02 returns 0x5A with PKTEND.
- FIFO4 full for 5 cycles during a READ_IN second byte -> no SLWR while full, byte 0x12 held, exactly 2 writes total.
- EDGE_EN: bit 3 pulses, then 0x03 -> response 0x08, 0x00. An immediate second 0x03 -> 0x00, 0x00. Without the macro, 0x03 produces no FIFO4 traffic.
